// File: rtl/ps2_seq_pkg.sv
// Shared types and constants for the PS/2 key sequencer: FSM states,
// Set-2 prefix bytes and the packed event layout {ext, break, code}.
package ps2_seq_pkg;

   typedef enum logic [1:0] {
      IDLE,
      EXT,
      BRK,
      EXT_BRK
   } seq_state_t;

   localparam logic [7:0] PS2_EXT_BYTE = 8'hE0;
   localparam logic [7:0] PS2_BRK_BYTE = 8'hF0;

   localparam int unsigned EVT_W        = 10;
   localparam int unsigned EVT_CODE_POS = 0;
   localparam int unsigned EVT_BRK_POS  = 8;
   localparam int unsigned EVT_EXT_POS  = 9;

   function automatic logic [EVT_W-1:0] pack_evt(input logic ext, input logic brk,
                                                  input logic [7:0] code);
      logic [EVT_W-1:0] e;
      e = '0;
      e[EVT_EXT_POS] = ext;
      e[EVT_BRK_POS] = brk;
      e[EVT_CODE_POS +: 8] = code;
      return e;
   endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// First-word-fall-through FIFO for key events; head reads as zero when empty.
// A push on a full FIFO is accepted only if a pop happens in the same cycle.
module ps2_evt_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 10
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned LVL_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             wr_ok;
   logic             rd_ok;

   assign empty = (level == '0);
   assign full  = (level == LVL_W'(DEPTH));
   assign rd_ok = pop && !empty;
   assign wr_ok = push && (!full || rd_ok);
   assign rdata = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_ptr] <= wdata;
   end

   // Power-of-two depth lets the pointers wrap by natural overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + PTR_W'(1);
         if (rd_ok) rd_ptr <= rd_ptr + PTR_W'(1);
         case ({wr_ok, rd_ok})
            2'b10:   level <= level + LVL_W'(1);
            2'b01:   level <= level - LVL_W'(1);
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/ps2_key_sequencer.sv
// Decodes PS/2 Set-2 E0/F0 prefixes into key events queued in a ready/valid FIFO,
// and holds the last make code for the display. Optional idle timeout: PS2_SEQ_TIMEOUT_EN.
module ps2_key_sequencer
   import ps2_seq_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH     = 4,
   parameter int unsigned TIMEOUT_CYCLES = 50000
) (
   input  logic                          CLOCK,
   input  logic                          RESET,
   input  logic [7:0]                    RX_DATA,
   input  logic                          DATA_VALID,
   output logic [7:0]                    EVT_CODE,
   output logic                          EVT_BREAK,
   output logic                          EVT_EXT,
   output logic                          EVT_VALID,
   input  logic                          EVT_READY,
   output logic [7:0]                    DISP_DATA,
   output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL,
   output logic                          OVERFLOW,
   output logic                          SEQ_ERR
);

   seq_state_t       state, state_nxt;
   logic             emit;
   logic [EVT_W-1:0] emit_evt;
   logic             err;
   logic             is_pfx;
   logic             push_q;
   logic [EVT_W-1:0] push_evt_q;
   logic [EVT_W-1:0] head;
   logic             fifo_full;
   logic             fifo_empty;
   logic             pop;

`ifdef PS2_SEQ_TIMEOUT_EN
   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
   logic [TMO_W-1:0] tmo_cnt;
   logic             tmo_hit;

   assign tmo_hit = (state != IDLE) && !DATA_VALID && (tmo_cnt == TMO_LAST);

   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET)                                    tmo_cnt <= '0;
      else if (DATA_VALID || state == IDLE || tmo_hit) tmo_cnt <= '0;
      else                                           tmo_cnt <= tmo_cnt + TMO_W'(1);
   end
`else
   logic tmo_hit;
   assign tmo_hit = 1'b0;
`endif

   assign is_pfx = (RX_DATA == PS2_EXT_BYTE) || (RX_DATA == PS2_BRK_BYTE);

   always_comb begin
      state_nxt = state;
      emit      = 1'b0;
      emit_evt  = '0;
      err       = 1'b0;
      if (DATA_VALID) begin
         case (state)
            IDLE: begin
               if (RX_DATA == PS2_EXT_BYTE)      state_nxt = EXT;
               else if (RX_DATA == PS2_BRK_BYTE) state_nxt = BRK;
               else begin
                  emit     = 1'b1;
                  emit_evt = pack_evt(1'b0, 1'b0, RX_DATA);
               end
            end
            EXT: begin
               if (RX_DATA == PS2_BRK_BYTE)      state_nxt = EXT_BRK;
               else if (RX_DATA == PS2_EXT_BYTE) state_nxt = EXT;
               else begin
                  emit      = 1'b1;
                  emit_evt  = pack_evt(1'b1, 1'b0, RX_DATA);
                  state_nxt = IDLE;
               end
            end
            BRK, EXT_BRK: begin
               state_nxt = IDLE;
               if (is_pfx) err = 1'b1;
               else begin
                  emit     = 1'b1;
                  emit_evt = pack_evt(state == EXT_BRK, 1'b1, RX_DATA);
               end
            end
            default: state_nxt = IDLE;
         endcase
      end else if (tmo_hit) begin
         state_nxt = IDLE;
         err       = 1'b1;
      end
   end

   assign pop = EVT_VALID && EVT_READY;

   // Emitted events are staged one cycle so the FIFO write and display update land together.
   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         state      <= IDLE;
         push_q     <= 1'b0;
         push_evt_q <= '0;
         SEQ_ERR    <= 1'b0;
         OVERFLOW   <= 1'b0;
         DISP_DATA  <= '0;
      end else begin
         state      <= state_nxt;
         push_q     <= emit;
         push_evt_q <= emit_evt;
         SEQ_ERR    <= err;
         OVERFLOW   <= push_q && fifo_full && !pop;
         if (push_q && !push_evt_q[EVT_BRK_POS])
            DISP_DATA <= push_evt_q[EVT_CODE_POS +: 8];
      end
   end

   ps2_evt_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (EVT_W)
   ) u_fifo (
      .clk   (CLOCK),
      .rst_n (RESET),
      .push  (push_q),
      .wdata (push_evt_q),
      .pop   (pop),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (FIFO_LEVEL)
   );

   assign EVT_VALID = !fifo_empty;
   assign EVT_CODE  = head[EVT_CODE_POS +: 8];
   assign EVT_BREAK = head[EVT_BRK_POS];
   assign EVT_EXT   = head[EVT_EXT_POS];

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Scoreboard bench for ps2_key_sequencer: stimulus queues expected events,
// a negedge monitor checks every accepted head event.
module tb_ps2_key_sequencer;

   logic       CLOCK = 1'b0;
   logic       RESET = 1'b0;
   logic [7:0] RX_DATA = '0;
   logic       DATA_VALID = 1'b0;
   logic [7:0] EVT_CODE;
   logic       EVT_BREAK;
   logic       EVT_EXT;
   logic       EVT_VALID;
   logic       EVT_READY = 1'b0;
   logic [7:0] DISP_DATA;
   logic [2:0] FIFO_LEVEL;
   logic       OVERFLOW;
   logic       SEQ_ERR;

   int checks   = 0;
   int failures = 0;
   logic [9:0] exp_q[$];

   ps2_key_sequencer #(
      .FIFO_DEPTH     (4),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .CLOCK      (CLOCK),
      .RESET      (RESET),
      .RX_DATA    (RX_DATA),
      .DATA_VALID (DATA_VALID),
      .EVT_CODE   (EVT_CODE),
      .EVT_BREAK  (EVT_BREAK),
      .EVT_EXT    (EVT_EXT),
      .EVT_VALID  (EVT_VALID),
      .EVT_READY  (EVT_READY),
      .DISP_DATA  (DISP_DATA),
      .FIFO_LEVEL (FIFO_LEVEL),
      .OVERFLOW   (OVERFLOW),
      .SEQ_ERR    (SEQ_ERR)
   );

   always #5 CLOCK = ~CLOCK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // {ext, break, code}
   function automatic logic [9:0] ev(input logic ext, input logic brk, input logic [7:0] code);
      return {ext, brk, code};
   endfunction

   task automatic send_byte(input logic [7:0] b);
      @(posedge CLOCK); #1;
      RX_DATA = b;
      DATA_VALID = 1'b1;
      @(posedge CLOCK); #1;
      DATA_VALID = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge CLOCK); #1;
      end
   endtask

   always @(negedge CLOCK) begin
      if (RESET && EVT_VALID && EVT_READY) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL evt_unexpected actual=%0h required=none", {EVT_EXT, EVT_BREAK, EVT_CODE});
         end else begin
            chk("evt_head", {22'd0, EVT_EXT, EVT_BREAK, EVT_CODE}, {22'd0, exp_q.pop_front()});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      int seen;
      // Reset state
      idle(2);
      chk("rst_valid", EVT_VALID, 0);
      chk("rst_head", {EVT_EXT, EVT_BREAK, EVT_CODE}, 0);
      chk("rst_disp", DISP_DATA, 0);
      chk("rst_level", FIFO_LEVEL, 0);
      chk("rst_pulses", {OVERFLOW, SEQ_ERR}, 0);
      RESET = 1'b1;
      idle(2);

      // Plain make code and its latency
      exp_q.push_back(ev(0, 0, 8'h1C));
      send_byte(8'h1C);
      chk("lat_valid_early", EVT_VALID, 0);
      idle(1);
      chk("lat_valid", EVT_VALID, 1);
      chk("lat_disp", DISP_DATA, 8'h1C);
      chk("lat_level", FIFO_LEVEL, 1);
      EVT_READY = 1'b1;
      idle(3);

      // Break codes leave the display alone
      exp_q.push_back(ev(0, 1, 8'h1C));
      send_byte(8'hF0); send_byte(8'h1C);
      exp_q.push_back(ev(0, 1, 8'h22));
      send_byte(8'hF0); send_byte(8'h22);
      idle(3);
      chk("brk_disp", DISP_DATA, 8'h1C);

      exp_q.push_back(ev(1, 1, 8'h75));
      send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
      idle(3);
      chk("extbrk_disp", DISP_DATA, 8'h1C);
      exp_q.push_back(ev(1, 0, 8'h75));
      send_byte(8'hE0); send_byte(8'h75);
      idle(3);
      chk("ext_disp", DISP_DATA, 8'h75);

      // E1 and AA are ordinary codes; repeated E0 stays extended
      exp_q.push_back(ev(0, 0, 8'hE1));
      send_byte(8'hE1);
      exp_q.push_back(ev(0, 1, 8'hAA));
      send_byte(8'hF0); send_byte(8'hAA);
      exp_q.push_back(ev(1, 0, 8'h6B));
      send_byte(8'hE0); send_byte(8'hE0); send_byte(8'h6B);
      idle(3);

      // Overflow with the consumer stalled
      EVT_READY = 1'b0;
      for (int i = 0; i < 4; i++) exp_q.push_back(ev(0, 0, 8'h11 + 8'(i)));
      for (int i = 0; i < 5; i++) send_byte(8'h11 + 8'(i));
      chk("ovf_early", OVERFLOW, 0);
      idle(1);
      chk("ovf_pulse", OVERFLOW, 1);
      chk("ovf_level", FIFO_LEVEL, 4);
      chk("ovf_disp", DISP_DATA, 8'h15);
      idle(1);
      chk("ovf_single", OVERFLOW, 0);
      EVT_READY = 1'b1;
      idle(8);
      chk("ovf_drained", FIFO_LEVEL, 0);

      // Full FIFO with a pop in the write cycle: nothing dropped
      EVT_READY = 1'b0;
      for (int i = 0; i < 5; i++) exp_q.push_back(ev(0, 0, 8'h21 + 8'(i)));
      for (int i = 0; i < 4; i++) send_byte(8'h21 + 8'(i));
      send_byte(8'h25);
      EVT_READY = 1'b1;
      @(posedge CLOCK); #1;
      EVT_READY = 1'b0;
      chk("popw_no_ovf", OVERFLOW, 0);
      chk("popw_level", FIFO_LEVEL, 4);
      chk("popw_disp", DISP_DATA, 8'h25);
      idle(1);
      chk("popw_no_ovf2", OVERFLOW, 0);
      EVT_READY = 1'b1;
      idle(8);

      // Illegal prefix order
      send_byte(8'hF0); send_byte(8'hE0);
      chk("err_pulse", SEQ_ERR, 1);
      idle(1);
      chk("err_single", SEQ_ERR, 0);
      chk("err_no_evt", FIFO_LEVEL, 0);
      send_byte(8'hE0); send_byte(8'hF0); send_byte(8'hF0);
      chk("err_extbrk", SEQ_ERR, 1);
      exp_q.push_back(ev(0, 0, 8'h1C));
      send_byte(8'h1C);
      idle(3);

`ifdef PS2_SEQ_TIMEOUT_EN
      // Prefix followed by silence
      send_byte(8'hE0);
      seen = 0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge CLOCK); #1;
         if (SEQ_ERR) begin
            seen = k;
            break;
         end
      end
      chk("tmo_cycles", seen, 16);
      exp_q.push_back(ev(0, 0, 8'h1C));
      send_byte(8'h1C);
      idle(3);
`else
      seen = 0;
`endif

      // Asynchronous reset in the middle of a prefix with a queued event
      EVT_READY = 1'b0;
      send_byte(8'h33);
      send_byte(8'hE0);
      RESET = 1'b0;
      #2;
      chk("amid_valid", EVT_VALID, 0);
      chk("amid_head", {EVT_EXT, EVT_BREAK, EVT_CODE}, 0);
      chk("amid_level", FIFO_LEVEL, 0);
      chk("amid_disp", DISP_DATA, 0);
      idle(2);
      RESET = 1'b1;
      EVT_READY = 1'b1;
      exp_q.push_back(ev(0, 0, 8'h1C));
      send_byte(8'h1C);
      idle(4);
      chk("amid_disp2", DISP_DATA, 8'h1C);

      chk("sb_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ps2_key_sequencer.md
# ps2_key_sequencer

Controller between the PS/2 byte receiver and the two seven-segment transcoders. It decodes the PS/2 Set-2 prefix bytes E0 (extended) and F0 (break) into complete key events and queues them in a small ready/valid FIFO. It also holds a registered display byte, the last make code, which drives both digit transcoders. This replaces the unregistered hold on the display nibbles.

## Interface
Parameters:
- FIFO_DEPTH, 4: event FIFO entries; power of two, ≥2.
- TIMEOUT_CYCLES, 50000: idle cycles allowed mid-sequence (1 ms at 50 MHz); ≥2.

Ports:
- CLOCK  in  1  single clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-low reset.
- RX_DATA  in  8  byte from the PS/2 receiver; valid only when DATA_VALID=1.
- DATA_VALID  in  1  one-cycle pulse per received byte.
- EVT_CODE  out  8  scan code at the FIFO head.
- EVT_BREAK  out  1  head event is a release.
- EVT_EXT  out  1  head event was E0-prefixed.
- EVT_VALID  out  1  FIFO not empty.
- EVT_READY  in  1  consumer accepts the head event when EVT_VALID&EVT_READY.
- DISP_DATA  out  8  last make code; [3:0] feeds digit 1 and [7:4] feeds digit 2.
- FIFO_LEVEL  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- OVERFLOW  out  1  one-cycle pulse when an event is dropped.
- SEQ_ERR  out  1  one-cycle pulse on a malformed or timed-out sequence.

## Operation
- Reset values: state IDLE, FIFO empty, and every output 0.
- The FSM advances only on cycles with DATA_VALID=1.
- IDLE:
  - E0 → EXT.
  - F0 → BRK.
  - Any other byte → emit {code, break=0, ext=0}, stay in IDLE.
- EXT:
  - F0 → EXT_BRK.
  - E0 → stay in EXT.
  - Other byte → emit {code, 0, 1}, go to IDLE.
- BRK:
  - Other byte → emit {code, 1, 0}, go to IDLE.
  - E0 or F0 → byte discarded, SEQ_ERR pulse, go to IDLE.
- EXT_BRK:
  - Other byte → emit {code, 1, 1}, go to IDLE.
  - E0 or F0 → byte discarded, SEQ_ERR pulse, go to IDLE.
- All codes other than E0 and F0 are ordinary codes, including E1 and AA.
- Emit writes the 10-bit event {ext, break, code} to the FIFO.
- Full FIFO: the event is dropped and OVERFLOW pulses.
  - Exception: if a pop occurs in the same cycle, the write is accepted and nothing is dropped.
- DISP_DATA loads the code on every make event (break=0), even if that event was dropped on overflow. Break events never change DISP_DATA.
- FIFO is first-word-fall-through: EVT_CODE, EVT_BREAK and EVT_EXT always show the head entry, and are 0 when empty.
- Simultaneous push and pop on an empty FIFO is impossible, because EVT_VALID=0.
- Pointers wrap modulo FIFO_DEPTH.

## Timing
- A byte on DATA_VALID at edge N produces the FSM transition at edge N.
- A completing byte at edge N produces:
  - the FIFO write at edge N+1;
  - EVT_VALID=1 in cycle N+1 when the FIFO was empty;
  - DISP_DATA updated at edge N+1.
- Pop happens at the edge where EVT_VALID&EVT_READY. The next head appears in the following cycle.
- OVERFLOW and SEQ_ERR are registered single-cycle pulses, asserted in the cycle after the causing edge.
- Reset asserted mid-sequence or mid-transfer clears everything immediately. Partial prefixes are lost.

## Configuration
- PS2_SEQ_TIMEOUT_EN defined:
  - A counter runs while the FSM is not in IDLE and clears on every DATA_VALID.
  - When it reaches TIMEOUT_CYCLES-1 with no byte, the FSM returns to IDLE and SEQ_ERR pulses.
  - DATA_VALID in the timeout cycle takes priority: the byte is processed in the current state and the counter clears.
- PS2_SEQ_TIMEOUT_EN undefined:
  - No counter is built.
  - A prefix waits indefinitely.
  - SEQ_ERR comes only from illegal prefix order.

## Structure
- Package ps2_seq_pkg holds:
  - the state enum IDLE/EXT/BRK/EXT_BRK;
  - the constants PS2_EXT_BYTE=8'hE0 and PS2_BRK_BYTE=8'hF0;
  - the event width (10) and the event field offsets.
- Sub-module ps2_evt_fifo is a parameterised FWFT FIFO with push, pop, full, empty and level. The FSM, timeout counter and display register stay in the top level.

## Test plan
- Byte 1C → event {1C,0,0} with EVT_VALID one cycle after the byte; DISP_DATA=1C.
- Bytes F0,1C → event {1C,1,0}; DISP_DATA unchanged from its prior value.
- Bytes E0,F0,75 → event {75,1,1}; bytes E0,75 → event {75,0,1} and DISP_DATA=75.
- EVT_READY=0, 5 make codes with FIFO_DEPTH=4 → FIFO_LEVEL=4 and one OVERFLOW pulse; DISP_DATA=5th code. Repeat with a pop in the 5th write cycle → no OVERFLOW.
- Bytes F0,E0 → SEQ_ERR pulse and no event; next byte 1C → {1C,0,0}.
- With PS2_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=16: E0 then silence → SEQ_ERR after 16 cycles, then 1C → {1C,0,0}. Separately, RESET low after E0 → outputs 0 and FIFO empty.
